serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial pattern transmitter: accepts a parallel word through a ready/load handshake and shifts it out MSB-first on a single serial line `x`, one bit per clock. It is the driving end of the serial line consumed by the zero-run (`000x`) Moore detectors in this design. It idles the line high so that the downstream detectors settle to their start state between words. An optional built-in model predicts the detector output cycle-by-cycle for self-checking benches.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `din` input WIDTH: word to transmit; sampled only on an accepted load.
- `load` input 1: load request; accepted when `load && ready` at a rising edge.
- `ready` output 1: high only in IDLE.
- `x` output 1: serial data, registered; idle level 1.
- `busy` output 1: high in SHIFT and DONE.
- `done` output 1: one-cycle pulse in DONE, after the last bit.
- `y_exp` output 1: predicted detector output. Present only with `SERIAL_TX_EXPECT_EN`.

## Operation
- Moore FSM with 3 states. All outputs are decoded from registers only.
- **IDLE**
  - `ready`=1, `busy`=0, `x`=1.
  - On `load && ready`: latch `din` into the shift register, clear the bit counter, go to SHIFT.
- **SHIFT**
  - `x` = shift register MSB.
  - Each clock: shift left by 1 and increment the counter.
  - After WIDTH bits have been presented, go to DONE.
  - `load` is ignored here (`ready`=0).
- **DONE**
  - `x`=1, `done`=1, `busy`=1.
  - Unconditionally go to IDLE on the next clock.
- Counter width is `$clog2(WIDTH+1)`. The last-bit compare is `cnt == WIDTH-1`. The counter never wraps.
- **Reset** (asserted at any time, including mid-word):
  - Immediately: state IDLE, `x`=1, `ready`=1, `busy`=0, `done`=0, counter 0, shift register 0.
  - The partial word is discarded.
- **Reset deassert coincident with a clock edge:** that edge does not accept `load`.
- A `load` held high through DONE is accepted on the first IDLE edge.

## Timing
- Load accepted at edge E0:
  - `x` carries `din[WIDTH-1]` in the cycle after E0.
  - Bit `din[WIDTH-1-i]` is on `x` in cycle i+1 after E0.
- `done` is high in cycle WIDTH+1 after E0.
- `ready` returns high in cycle WIDTH+2 after E0.
- Maximum throughput: one word per WIDTH+2 cycles.
- Between words, `x` is 1 for at least 2 cycles (DONE and IDLE).
- Reset values:
  - `x`=1, `ready`=1, `busy`=0, `done`=0.
  - `y_exp`=0 (when present).

## Configuration
- Macro: `SERIAL_TX_EXPECT_EN`.
- **Defined:** instantiates the detector model and the `y_exp` port.
  - A 3-bit history register `hist` samples `x` every clock, including idle cycles.
  - `y_exp <= (hist == 3'b000)`, then `hist <= {hist[1:0], x}`.
  - Result: `y_exp` is high in the cycle after any bit that follows three consecutive 0s on `x`. This matches the registered Moore detector output for the `000x` pattern.
  - Reset: `hist`=3'b111, `y_exp`=0.
- **Undefined:** no history logic and no `y_exp` port. All other behaviour is identical.

## Structure
- Shared package `serial_tx_pkg` contains:
  - State encodings: `ST_IDLE`=2'b00, `ST_SHIFT`=2'b01, `ST_DONE`=2'b10. Code 2'b11 is illegal and recovers to IDLE.
  - `IDLE_LEVEL`=1'b1.
  - `HIST_RESET`=3'b111.
- Sub-module `zero_run_model`:
  - Contains the `hist`/`y_exp` logic.
  - Ports: `clk`, `reset`, `x`, `y_exp`.
  - Instantiated only under `SERIAL_TX_EXPECT_EN`.
- FSM, counter and shift register stay in the top module.

## Test plan
All scenarios use WIDTH=8.
1. Reset, then load `din`=8'hA5 at E0 → `x` = 1,0,1,0,0,1,0,1 in cycles 1..8; `done` high in cycle 9 only; `ready` high in cycle 10.
2. `din`=8'h10 with EXPECT_EN → `x` = 0,0,0,1,0,0,0,0; `y_exp` high in cycle 5 (after the 1) and in cycles 9, 10 (after bits 8 and the idle 1), else 0.
3. `din`=8'h00 with EXPECT_EN → `y_exp` high in cycles 5..10 continuously; low from cycle 11.
4. `load` held high continuously with words 8'hFF then 8'h0F → second word starts exactly in cycle 11 after E0; `ready` low for 9 cycles per word.
5. `load` pulsed while `busy` → ignored; transmitted word is unchanged.
6. Reset asserted in cycle 4 of a word → `x`=1, `ready`=1, `busy`=0 immediately; a new `load` after release transmits from bit 7 cleanly.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared types and constants for the serial pattern transmitter.
// Holds FSM state codes, the idle line level and the detector-model history reset.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic       IDLE_LEVEL = 1'b1;
  localparam logic [2:0] HIST_RESET = 3'b111;

endpackage

// File: rtl/zero_run_model.sv
// zero_run_model: predicts the registered 000x Moore detector output.
// Ports: clk, reset (async, active-low), x (serial in), y_exp (prediction).
module zero_run_model
  import serial_tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic y_exp
);

  logic [2:0] hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= HIST_RESET;
      y_exp  <= 1'b0;
    end else begin
      y_exp  <= (hist_q == 3'b000);
      hist_q <= {hist_q[1:0], x};
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: loads a WIDTH-bit word on load&&ready, shifts it MSB-first
// onto x, then pulses done. Ports: clk, reset (async, active-low), din, load,
// ready, x, busy, done; y_exp only when SERIAL_TX_EXPECT_EN is defined.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             x,
  output logic             busy,
`ifdef SERIAL_TX_EXPECT_EN
  output logic             done,
  output logic             y_exp
`else
  output logic             done
`endif
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q;

  // The first edge after reset release only arms the block, so a
  // release landing on a clock edge can never start a word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load && armed_q) begin
          state_d = ST_SHIFT;
          sreg_d  = din;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_SHIFT) ||
                 (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign x     = (state_q == ST_SHIFT) ?
                 sreg_q[WIDTH-1] : IDLE_LEVEL;

`ifdef SERIAL_TX_EXPECT_EN
  zero_run_model u_model (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y_exp (y_exp)
  );
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed self-checking bench for serial_pattern_tx.
// WIDTH=8; y_exp is checked when SERIAL_TX_EXPECT_EN is defined.
module tb_serial_pattern_tx;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       load;
  logic       ready;
  logic       x;
  logic       busy;
  logic       done;
`ifdef SERIAL_TX_EXPECT_EN
  logic       y_exp;
`endif

  int errors = 0;
  int checks = 0;

  serial_pattern_tx #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .load  (load),
    .ready (ready),
    .x     (x),
    .busy  (busy),
`ifdef SERIAL_TX_EXPECT_EN
    .done  (done),
    .y_exp (y_exp)
`else
    .done  (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  // Sends w (accepted at the next posedge, E0) and checks cycles 1..11.
  // ym bit k is the expected y_exp in cycle k; pk>0 pulses load in
  // cycle pk with a different word, which must be ignored.
  task automatic run_word(input string nm,
                          input logic [7:0] w,
                          input logic [11:0] ym,
                          input int pk);
    logic ex;
    load = 1'b1;
    din  = w;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      ex = (k <= 8) ? w[8-k] : 1'b1;
      chk($sformatf("%s x c%0d", nm, k), 32'(x), 32'(ex));
      chk($sformatf("%s done c%0d", nm, k),
          32'(done), 32'(k == 9));
      chk($sformatf("%s ready c%0d", nm, k),
          32'(ready), 32'(k >= 10));
      chk($sformatf("%s busy c%0d", nm, k),
          32'(busy), 32'(k <= 9));
`ifdef SERIAL_TX_EXPECT_EN
      chk($sformatf("%s y_exp c%0d", nm, k),
          32'(y_exp), 32'(ym[k]));
`endif
      if (k == pk) begin
        load = 1'b1;
        din  = 8'hFF;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] w1;
    logic [7:0] w2;
    logic       ex;
    int         rl;

    reset = 1'b0;
    load  = 1'b0;
    din   = 8'h00;

    #2;
    chk("reset x", 32'(x), 32'd1);
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
`ifdef SERIAL_TX_EXPECT_EN
    chk("reset y_exp", 32'(y_exp), 32'd0);
`endif

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    run_word("a5", 8'hA5, 12'h000, 0);
    run_word("10", 8'h10, 12'h620, 0);
    run_word("00", 8'h00, 12'h7E0, 0);

    // load held high: FF then 0F back to back
    w1   = 8'hFF;
    w2   = 8'h0F;
    rl   = 0;
    load = 1'b1;
    din  = w1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 8)       ex = w1[8-k];
      else if (k <= 10) ex = 1'b1;
      else if (k <= 18) ex = w2[18-k];
      else              ex = 1'b1;
      chk($sformatf("hold x c%0d", k), 32'(x), 32'(ex));
      chk($sformatf("hold done c%0d", k),
          32'(done), 32'(k == 9 || k == 19));
      chk($sformatf("hold ready c%0d", k),
          32'(ready), 32'(k == 10 || k == 20));
`ifdef SERIAL_TX_EXPECT_EN
      chk($sformatf("hold y_exp c%0d", k),
          32'(y_exp), 32'(k == 15 || k == 16));
`endif
      if (k <= 10 && ready === 1'b0) rl++;
      if (k == 2)  din  = w2;
      if (k == 11) load = 1'b0;
    end
    chk("hold ready-low cycles", 32'(rl), 32'd9);

    run_word("busy-load", 8'h3C, 12'h000, 3);

    // reset in cycle 4 of a word
    load = 1'b1;
    din  = 8'hA5;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("mid x before reset", 32'(x), 32'd0);
    chk("mid busy before reset", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid reset x", 32'(x), 32'd1);
    chk("mid reset ready", 32'(ready), 32'd1);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset done", 32'(done), 32'd0);
`ifdef SERIAL_TX_EXPECT_EN
    chk("mid reset y_exp", 32'(y_exp), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_word("post-reset", 8'hC3, 12'h180, 0);

    // release coincident with an edge: that edge takes no load
    reset = 1'b0;
    @(negedge clk);
    load = 1'b1;
    din  = 8'h81;
    @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("coinc ready", 32'(ready), 32'd1);
    chk("coinc busy", 32'(busy), 32'd0);
    @(negedge clk);
    load = 1'b0;
    chk("coinc next busy", 32'(busy), 32'd1);
    chk("coinc next x", 32'(x), 32'd1);
    @(negedge clk);
    chk("coinc bit6 x", 32'(x), 32'd0);
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("coinc end ready", 32'(ready), 32'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
